ft_lockstep_ctrl: RTL and testbench
===================================

# ft_lockstep_ctrl

Parametrised lockstep fault-tolerance controller for 2 or 3 redundant zeroriscy cores. It compares every register-file write port each cycle and keeps a golden shadow register file plus a checkpoint PC. On divergence it halts all cores through the debug port, rewrites every GPR and the next PC from the shadow state, then resumes them. It supersedes the dual-core compare/restore path in the SoC top, adding configurable core count, majority voting and fault identification.

## Interface
- N_CORES, 2, redundant cores; legal values 2 (DMR, rollback) or 3 (TMR, forward correction)
- DATA_W, 32, register data width
- N_REGS, 32, GPRs restored; 16 for RV32E
- DBG_GPR_BASE, 15'h400, debug address of x0
- DBG_NPC_ADDR, 15'h2000, debug address of next PC
- clk_i  in  1  core clock
- rst_ni  in  1  reset, asynchronous, active-low
- we_i  in  N_CORES  per-core regfile write enable
- waddr_i  in  N_CORES*5  per-core write address, core k at [5k+4:5k]
- wdata_i  in  N_CORES*DATA_W  per-core write data
- wb_pc_i  in  32  PC of the instruction producing core 0's write
- dbg_halted_i  in  N_CORES  per-core debug_halted
- halt_o  out  1  debug_halt to all cores
- resume_o  out  1  debug_resume to all cores, one-cycle pulse
- dbg_we_o  out  1  debug write strobe to all cores
- dbg_addr_o  out  15  debug address
- dbg_wdata_o  out  DATA_W  debug write data
- busy_o  out  1  recovery in progress
- err_o  out  1  one-cycle pulse per detected mismatch
- faulty_o  out  N_CORES  outvoted core mask (TMR), all ones on DMR mismatch
- err_count_o  out  16  saturating error count (FT_ERR_LOG_EN only)
- err_pc_o  out  32  wb_pc_i of last mismatch (FT_ERR_LOG_EN only)

## Operation
- Per-core tuple = {we, waddr, wdata}; waddr/wdata ignored when we=0. Match = tuples equal.
- All match: if we=1 and waddr!=0, shadow[waddr] <= wdata; checkpoint PC <= wb_pc_i+4.
- N_CORES=3, exactly one core disagrees: shadow updated from majority tuple; checkpoint <= wb_pc_i+4; faulty_o = that core's bit; recovery starts.
- N_CORES=3, all three differ, or N_CORES=2 with any mismatch: shadow unchanged; checkpoint <= wb_pc_i (re-execute); faulty_o all ones; recovery starts.
- FSM: IDLE -> HALT -> COPY -> NPC -> RESUME -> IDLE.
- HALT: halt_o=1 until dbg_halted_i all ones.
- COPY: idx 0..N_REGS-1, one per cycle; dbg_we_o=1, dbg_addr_o=DBG_GPR_BASE+4*idx, dbg_wdata_o=shadow[idx] (x0 reads 0).
- NPC: one cycle, dbg_we_o=1, dbg_addr_o=DBG_NPC_ADDR, dbg_wdata_o=checkpoint.
- RESUME: halt_o=0, resume_o=1 one cycle.
- Outside IDLE comparison disabled; no err_o, shadow/checkpoint frozen.

## Timing
- Reset: FSM IDLE; shadow all 0; checkpoint 0; all outputs 0.
- Inputs sampled at edge t; err_o, faulty_o, halt_o, busy_o asserted in cycle t+1 (registered).
- HALT exit on the edge where dbg_halted_i is all ones; COPY starts next cycle; no timeout.
- Recovery length after halt = N_REGS+2 cycles; busy_o high HALT through RESUME inclusive.
- halt_o held through COPY and NPC; drops in RESUME.
- faulty_o holds until next err_o.
- Reset mid-recovery: immediate return to IDLE, halt_o/dbg_we_o low asynchronously.
- Legality: dbg_we_o never high in IDLE/HALT/RESUME.

## Configuration
- FT_ERR_LOG_EN defined: err_count_o increments on each err_o, saturating at 16'hFFFF; err_pc_o captures wb_pc_i at detection; both reset to 0.
- Undefined: counter/capture registers absent; err_count_o and err_pc_o tied to 0.

## Test plan
- N=3, all cores write x5=32'h1234 at wb_pc 0x100 -> no err_o; debug-read proves shadow[5]=0x1234 after later forced recovery, checkpoint 0x104.
- N=3, core 1 writes x7=0xDEAD, others 0xBEEF at pc 0x200 -> err_o at t+1, faulty_o=3'b010, COPY writes addr 0x41C with 0xBEEF, NPC write 0x204, resume_o pulse.
- N=2, mismatch x3 0x1 vs 0x2 at pc 0x300, shadow[3]=0x9 -> restore 0x9 to addr 0x40C, NPC 0x300, faulty_o=2'b11.
- dbg_halted_i delayed 5 cycles for core 2 -> halt_o held, no dbg_we_o until all halted; COPY exactly N_REGS cycles.
- Second mismatch injected during COPY -> ignored, single err_o; reset asserted mid-COPY -> all outputs 0 immediately, shadow cleared.
- FT_ERR_LOG_EN: 3 mismatches -> err_count_o=3, err_pc_o=last pc; undefined -> both read 0.

Source files
------------

// File: rtl/ft_lockstep_ctrl.sv
// ft_lockstep_ctrl: lockstep fault-tolerance controller for 2 (DMR) or 3 (TMR)
// redundant cores. It compares the cores' register-file write ports each cycle
// and keeps a golden shadow register file plus a checkpoint PC. On a divergence
// it halts the cores, rewrites every GPR and the next PC over the debug port,
// and then resumes them.
// Optional feature macro: FT_ERR_LOG_EN adds an error counter and an error-PC
// capture. Without it, err_count_o and err_pc_o are tied to 0.
`timescale 1ns/1ps
module ft_lockstep_ctrl #(
   parameter int          N_CORES      = 2,
   parameter int          DATA_W       = 32,
   parameter int          N_REGS       = 32,
   parameter logic [14:0] DBG_GPR_BASE = 15'h400,
   parameter logic [14:0] DBG_NPC_ADDR = 15'h2000
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [N_CORES-1:0]          we_i,
   input  logic [N_CORES*5-1:0]        waddr_i,
   input  logic [N_CORES*DATA_W-1:0]   wdata_i,
   input  logic [31:0]                 wb_pc_i,
   input  logic [N_CORES-1:0]          dbg_halted_i,
   output logic                        halt_o,
   output logic                        resume_o,
   output logic                        dbg_we_o,
   output logic [14:0]                 dbg_addr_o,
   output logic [DATA_W-1:0]           dbg_wdata_o,
   output logic                        busy_o,
   output logic                        err_o,
   output logic [N_CORES-1:0]          faulty_o,
   output logic [15:0]                 err_count_o,
   output logic [31:0]                 err_pc_o
);

   localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
   localparam int TUP_W = DATA_W + 6;

   typedef enum logic [2:0] {S_IDLE, S_HALT, S_COPY, S_NPC, S_RESUME} state_t;

   state_t                          state_reg, state_next;
   logic [IDX_W-1:0]                idx_reg;
   logic [DATA_W-1:0]               shadow_reg [N_REGS];
   logic [31:0]                     ckpt_reg;
   logic                            err_reg;
   logic [N_CORES-1:0]              faulty_reg;

   logic [N_CORES-1:0][TUP_W-1:0]   tup;
   logic                            all_match, minority;
   logic [N_CORES-1:0]              bad_mask;
   logic [TUP_W-1:0]                maj_tup;
   logic                            cmp_en, mismatch, commit;
   logic                            maj_we;
   logic [4:0]                      maj_waddr;
   logic [DATA_W-1:0]               maj_wdata;
   logic                            shadow_we;

   // Per-core write tuple; address and data are masked so idle ports compare equal.
   genvar gi;
   generate
      for (gi = 0; gi < N_CORES; gi++) begin : g_tup
         assign tup[gi] = we_i[gi] ? {1'b1, waddr_i[5*gi +: 5], wdata_i[DATA_W*gi +: DATA_W]}
                                   : '0;
      end
   endgenerate

   generate
      if (N_CORES == 3) begin : g_tmr
         logic eq01, eq02, eq12;
         assign eq01 = (tup[0] == tup[1]);
         assign eq02 = (tup[0] == tup[2]);
         assign eq12 = (tup[1] == tup[2]);
         // Majority vote: find the single outvoted core, if there is one.
         always_comb begin
            all_match = eq01 & eq02;
            minority  = 1'b0;
            bad_mask  = '1;
            maj_tup   = tup[0];
            if (all_match) begin
               bad_mask = '0;
            end else if (eq12) begin
               minority = 1'b1;
               bad_mask = 3'b001;
               maj_tup  = tup[1];
            end else if (eq02) begin
               minority = 1'b1;
               bad_mask = 3'b010;
            end else if (eq01) begin
               minority = 1'b1;
               bad_mask = 3'b100;
            end
         end
      end else begin : g_dmr
         // Two cores cannot tell which one is wrong: any difference is a rollback.
         always_comb begin
            all_match = (tup[0] == tup[1]);
            minority  = 1'b0;
            bad_mask  = '1;
            maj_tup   = tup[0];
         end
      end
   endgenerate

   assign cmp_en    = (state_reg == S_IDLE);
   assign mismatch  = cmp_en & ~all_match;
   assign commit    = cmp_en & (all_match | minority);
   assign maj_we    = maj_tup[TUP_W-1];
   assign maj_waddr = maj_tup[DATA_W +: 5];
   assign maj_wdata = maj_tup[DATA_W-1:0];
   assign shadow_we = commit & maj_we & (maj_waddr != 5'd0) & (32'(maj_waddr) < N_REGS);

   // Shadow register file: golden copy of the agreed GPR state (x0 never written).
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < N_REGS; i++) shadow_reg[i] <= '0;
      end else if (shadow_we) begin
         shadow_reg[IDX_W'(maj_waddr)] <= maj_wdata;
      end
   end

   // Checkpoint PC: advances past agreed writes, stays on the faulting
   // instruction when it has to be re-executed. Cycles with no write leave it alone.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ckpt_reg <= '0;
      end else if (mismatch || (commit && maj_we)) begin
         ckpt_reg <= (all_match || minority) ? wb_pc_i + 32'd4 : wb_pc_i;
      end
   end

   // Error pulse and outvoted-core mask; the mask holds until the next error.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_reg    <= 1'b0;
         faulty_reg <= '0;
      end else begin
         err_reg <= mismatch;
         if (mismatch) faulty_reg <= bad_mask;
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_reg <= S_IDLE;
      else         state_reg <= state_next;
   end

   // Next-state logic for the recovery sequence.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (mismatch) state_next = S_HALT;
         S_HALT:   if (&dbg_halted_i) state_next = S_COPY;
         S_COPY:   if (idx_reg == IDX_W'(N_REGS - 1)) state_next = S_NPC;
         S_NPC:    state_next = S_RESUME;
         S_RESUME: state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // GPR copy index, counts only while in COPY.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                  idx_reg <= '0;
      else if (state_reg == S_COPY) idx_reg <= idx_reg + 1'b1;
      else                          idx_reg <= '0;
   end

   // Debug-port outputs decoded from the state register.
   always_comb begin
      halt_o      = 1'b0;
      resume_o    = 1'b0;
      dbg_we_o    = 1'b0;
      dbg_addr_o  = '0;
      dbg_wdata_o = '0;
      busy_o      = (state_reg != S_IDLE);
      case (state_reg)
         S_HALT: halt_o = 1'b1;
         S_COPY: begin
            halt_o      = 1'b1;
            dbg_we_o    = 1'b1;
            dbg_addr_o  = DBG_GPR_BASE + 15'({idx_reg, 2'b00});
            dbg_wdata_o = (idx_reg == '0) ? '0 : shadow_reg[idx_reg];
         end
         S_NPC: begin
            halt_o      = 1'b1;
            dbg_we_o    = 1'b1;
            dbg_addr_o  = DBG_NPC_ADDR;
            dbg_wdata_o = DATA_W'(ckpt_reg);
         end
         S_RESUME: resume_o = 1'b1;
         default: ;
      endcase
   end

   assign err_o    = err_reg;
   assign faulty_o = faulty_reg;

`ifdef FT_ERR_LOG_EN
   logic [15:0] err_count_reg;
   logic [31:0] err_pc_reg;

   // Saturating error counter and PC of the most recent mismatch.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_count_reg <= '0;
         err_pc_reg    <= '0;
      end else if (mismatch) begin
         if (err_count_reg != 16'hFFFF) err_count_reg <= err_count_reg + 16'd1;
         err_pc_reg <= wb_pc_i;
      end
   end

   assign err_count_o = err_count_reg;
   assign err_pc_o    = err_pc_reg;
`else
   assign err_count_o = '0;
   assign err_pc_o    = '0;
`endif

endmodule

// File: tb/tb_ft_lockstep_ctrl.sv
// Directed bench for ft_lockstep_ctrl: one TMR instance (32 GPRs) and one DMR
// instance (16 GPRs) on a shared clock, each with its own reset.
`timescale 1ns/1ps
module tb_ft_lockstep_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // TMR instance signals
   logic        rst3_n;
   logic [2:0]  we3, halted3, faulty3;
   logic [14:0] waddr3, addr3;
   logic [95:0] wdata3;
   logic [31:0] pc3, dwd3, epc3;
   logic        halt3, resume3, dbgwe3, busy3, err3;
   logic [15:0] cnt3;

   // DMR instance signals
   logic        rst2_n;
   logic [1:0]  we2, halted2, faulty2;
   logic [9:0]  waddr2;
   logic [63:0] wdata2;
   logic [14:0] addr2;
   logic [31:0] pc2, dwd2, epc2;
   logic        halt2, resume2, dbgwe2, busy2, err2;
   logic [15:0] cnt2;

   ft_lockstep_ctrl #(.N_CORES(3), .DATA_W(32), .N_REGS(32)) dut3 (
      .clk_i(clk), .rst_ni(rst3_n), .we_i(we3), .waddr_i(waddr3), .wdata_i(wdata3),
      .wb_pc_i(pc3), .dbg_halted_i(halted3), .halt_o(halt3), .resume_o(resume3),
      .dbg_we_o(dbgwe3), .dbg_addr_o(addr3), .dbg_wdata_o(dwd3), .busy_o(busy3),
      .err_o(err3), .faulty_o(faulty3), .err_count_o(cnt3), .err_pc_o(epc3));

   ft_lockstep_ctrl #(.N_CORES(2), .DATA_W(32), .N_REGS(16)) dut2 (
      .clk_i(clk), .rst_ni(rst2_n), .we_i(we2), .waddr_i(waddr2), .wdata_i(wdata2),
      .wb_pc_i(pc2), .dbg_halted_i(halted2), .halt_o(halt2), .resume_o(resume2),
      .dbg_we_o(dbgwe2), .dbg_addr_o(addr2), .dbg_wdata_o(dwd2), .busy_o(busy2),
      .err_o(err2), .faulty_o(faulty2), .err_count_o(cnt2), .err_pc_o(epc2));

   int checks = 0;
   int errors = 0;
   bit use2 = 1'b0;
   logic [31:0] copy_q [32];

   logic        m_halt, m_resume, m_we, m_busy, m_err;
   logic [14:0] m_addr;
   logic [31:0] m_wdata;
   assign m_halt   = use2 ? halt2   : halt3;
   assign m_resume = use2 ? resume2 : resume3;
   assign m_we     = use2 ? dbgwe2  : dbgwe3;
   assign m_busy   = use2 ? busy2   : busy3;
   assign m_err    = use2 ? err2    : err3;
   assign m_addr   = use2 ? addr2   : addr3;
   assign m_wdata  = use2 ? dwd2    : dwd3;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive3(input logic [2:0] we, input logic [4:0] a0, a1, a2,
                         input logic [31:0] d0, d1, d2, input logic [31:0] pc);
      we3 = we; waddr3 = {a2, a1, a0}; wdata3 = {d2, d1, d0}; pc3 = pc;
      @(negedge clk);
      we3 = '0;
      $display("tmr write we=%b addr=%0d/%0d/%0d pc=%0h -> err=%b faulty=%b", we, a0, a1, a2, pc, err3, faulty3);
   endtask

   task automatic drive2(input logic [1:0] we, input logic [4:0] a0, a1,
                         input logic [31:0] d0, d1, input logic [31:0] pc);
      we2 = we; waddr2 = {a1, a0}; wdata2 = {d1, d0}; pc2 = pc;
      @(negedge clk);
      we2 = '0;
      $display("dmr write we=%b addr=%0d/%0d pc=%0h -> err=%b faulty=%b", we, a0, a1, pc, err2, faulty2);
   endtask

   task automatic set_halted(input bit full);
      if (use2) halted2 = full ? 2'b11 : 2'b01;
      else      halted3 = full ? 3'b111 : 3'b011;
   endtask

   // Entered on the negedge where the selected DUT has just reached HALT.
   task automatic do_recovery(input int n_regs, input int delay, input logic [31:0] exp_npc);
      for (int k = 0; k < delay; k++) begin
         set_halted(1'b0);
         check("halt_wait", 64'(m_halt), 1);
         check("no_we_wait", 64'(m_we), 0);
         @(negedge clk);
      end
      set_halted(1'b1);
      check("halt_hold", 64'(m_halt), 1);
      check("busy_halt", 64'(m_busy), 1);
      check("no_we_halt", 64'(m_we), 0);
      @(negedge clk);
      check("err_pulse", 64'(m_err), 0);
      for (int i = 0; i < n_regs; i++) begin
         check("copy_we", 64'(m_we), 1);
         check("copy_halt", 64'(m_halt), 1);
         check("copy_addr", 64'(m_addr), 64'(32'h400 + 4 * i));
         copy_q[i] = m_wdata;
         @(negedge clk);
      end
      check("npc_we", 64'(m_we), 1);
      check("npc_addr", 64'(m_addr), 'h2000);
      check("npc_data", 64'(m_wdata), 64'(exp_npc));
      @(negedge clk);
      check("resume", 64'(m_resume), 1);
      check("resume_halt", 64'(m_halt), 0);
      check("resume_we", 64'(m_we), 0);
      check("resume_busy", 64'(m_busy), 1);
      halted3 = '0;
      halted2 = '0;
      @(negedge clk);
      check("idle_busy", 64'(m_busy), 0);
      check("idle_resume", 64'(m_resume), 0);
      $display("recovery done n_regs=%0d delay=%0d npc=%0h", n_regs, delay, exp_npc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst3_n = 1'b0; rst2_n = 1'b0;
      we3 = '0; waddr3 = '0; wdata3 = '0; pc3 = '0; halted3 = '0;
      we2 = '0; waddr2 = '0; wdata2 = '0; pc2 = '0; halted2 = '0;
      repeat (2) @(negedge clk);
      check("rst_halt3", 64'(halt3), 0);
      check("rst_busy3", 64'(busy3), 0);
      check("rst_err3", 64'(err3), 0);
      check("rst_faulty3", 64'(faulty3), 0);
      check("rst_we3", 64'(dbgwe3), 0);
      check("rst_resume3", 64'(resume3), 0);
      check("rst_addr3", 64'(addr3), 0);
      check("rst_cnt3", 64'(cnt3), 0);
      check("rst_halt2", 64'(halt2), 0);
      check("rst_faulty2", 64'(faulty2), 0);
      rst3_n = 1'b1; rst2_n = 1'b1;
      @(negedge clk);

      // Agreed writes, a write to x0, and idle ports with differing junk
      drive3(3'b111, 5, 5, 5, 32'h1234, 32'h1234, 32'h1234, 32'h100);
      check("t1_err", 64'(err3), 0);
      check("t1_busy", 64'(busy3), 0);
      drive3(3'b111, 0, 0, 0, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'h100);
      check("x0_err", 64'(err3), 0);
      drive3(3'b000, 1, 2, 3, 32'h1, 32'h2, 32'h3, 32'h100);
      check("idle_err", 64'(err3), 0);

      // Core 1 outvoted on x7
      drive3(3'b111, 7, 7, 7, 32'hBEEF, 32'hDEAD, 32'hBEEF, 32'h200);
      check("t2_err", 64'(err3), 1);
      check("t2_faulty", 64'(faulty3), 'b010);
      check("t2_halt", 64'(halt3), 1);
      check("t2_busy", 64'(busy3), 1);
      check("t2_we", 64'(dbgwe3), 0);
      do_recovery(32, 0, 32'h204);
      check("t2_x7", 64'(copy_q[7]), 'hBEEF);
      check("t2_x5", 64'(copy_q[5]), 'h1234);
      check("t2_x0", 64'(copy_q[0]), 0);
      check("t2_faulty_hold", 64'(faulty3), 'b010);

      // All three differ: rollback, core 2 slow to halt
      drive3(3'b111, 9, 9, 9, 32'h1, 32'h2, 32'h3, 32'h104);
      check("t3_err", 64'(err3), 1);
      check("t3_faulty", 64'(faulty3), 'b111);
      do_recovery(32, 5, 32'h104);
      check("t3_x5", 64'(copy_q[5]), 'h1234);
      check("t3_x7", 64'(copy_q[7]), 'hBEEF);
      check("t3_x9", 64'(copy_q[9]), 0);

      // Core 0 outvoted, then a second mismatch during COPY, then reset mid-COPY
      drive3(3'b111, 4, 4, 4, 32'h11, 32'h22, 32'h22, 32'h400);
      check("t4_err", 64'(err3), 1);
      check("t4_faulty", 64'(faulty3), 'b001);
`ifdef FT_ERR_LOG_EN
      check("t4_cnt", 64'(cnt3), 3);
      check("t4_epc", 64'(epc3), 'h400);
`else
      check("t4_cnt", 64'(cnt3), 0);
      check("t4_epc", 64'(epc3), 0);
`endif
      halted3 = 3'b111;
      @(negedge clk);
      check("t4_copy0", 64'(addr3), 'h400);
      repeat (2) @(negedge clk);
      drive3(3'b111, 6, 6, 6, 32'h1, 32'h2, 32'h3, 32'h600);
      check("t4_2nd_err", 64'(err3), 0);
      check("t4_2nd_faulty", 64'(faulty3), 'b001);
      check("t4_2nd_addr", 64'(addr3), 'h40C);
      @(negedge clk);
      rst3_n = 1'b0;
      #1;
      check("t4_rst_halt", 64'(halt3), 0);
      check("t4_rst_we", 64'(dbgwe3), 0);
      check("t4_rst_busy", 64'(busy3), 0);
      check("t4_rst_faulty", 64'(faulty3), 0);
      check("t4_rst_cnt", 64'(cnt3), 0);
      @(negedge clk);
      rst3_n = 1'b1;
      halted3 = '0;
      @(negedge clk);
      drive3(3'b111, 9, 9, 9, 32'h4, 32'h5, 32'h6, 32'h500);
      check("t5_err", 64'(err3), 1);
      check("t5_faulty", 64'(faulty3), 'b111);
      do_recovery(32, 0, 32'h500);
      check("t5_x5", 64'(copy_q[5]), 0);
      check("t5_x7", 64'(copy_q[7]), 0);
      check("t5_x4", 64'(copy_q[4]), 0);
`ifdef FT_ERR_LOG_EN
      check("t5_cnt", 64'(cnt3), 1);
      check("t5_epc", 64'(epc3), 'h500);
`else
      check("t5_cnt", 64'(cnt3), 0);
      check("t5_epc", 64'(epc3), 0);
`endif

      // DMR instance
      use2 = 1'b1;
      drive2(2'b11, 3, 3, 32'h9, 32'h9, 32'h2F0);
      check("d1_err", 64'(err2), 0);
      drive2(2'b11, 3, 3, 32'h1, 32'h2, 32'h300);
      check("d2_err", 64'(err2), 1);
      check("d2_faulty", 64'(faulty2), 'b11);
      check("d2_halt", 64'(halt2), 1);
      do_recovery(16, 0, 32'h300);
      check("d2_x3", 64'(copy_q[3]), 'h9);
      drive2(2'b10, 3, 3, 32'h9, 32'h9, 32'h310);
      check("d3_err", 64'(err2), 1);
      check("d3_faulty", 64'(faulty2), 'b11);
      do_recovery(16, 3, 32'h310);
      check("d3_x3", 64'(copy_q[3]), 'h9);
`ifdef FT_ERR_LOG_EN
      check("d_cnt", 64'(cnt2), 2);
      check("d_epc", 64'(epc2), 'h310);
`else
      check("d_cnt", 64'(cnt2), 0);
      check("d_epc", 64'(epc2), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
